// File: rtl/ppu_vram_arb.sv
// PPU VRAM bus scheduler: one spr/bg/ri access per cycle into a 3-stage read pipeline.
// Optional ri anti-starvation timeout: define PPU_VRAM_ARB_RI_TIMEOUT_EN.
`timescale 1ns/1ps

module ppu_vram_arb #(
  parameter int unsigned RI_WAIT_MAX = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        spr_req_in,
  input  logic [13:0] spr_a_in,
  output logic        spr_gnt_out,
  input  logic        bg_req_in,
  input  logic [13:0] bg_a_in,
  output logic        bg_gnt_out,
  input  logic        ri_req_in,
  input  logic        ri_wr_in,
  input  logic [13:0] ri_a_in,
  input  logic [7:0]  ri_d_in,
  output logic        ri_ack_out,
  output logic [7:0]  ri_d_out,
  input  logic [7:0]  vram_d_in,
  output logic [13:0] vram_a_out,
  output logic [7:0]  vram_d_out,
  output logic        vram_wr_out,
  output logic [7:0]  rd_d_out,
  output logic        rd_vld_out,
  output logic [1:0]  rd_owner_out
);

  // Encoding doubles as the rd_owner_out tag.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_BG   = 2'b01,
    OWN_SPR  = 2'b10,
    OWN_RI   = 2'b11
  } owner_e;

  owner_e win;
  owner_e s1_owner;
  owner_e s2_owner;
  logic   ri_busy;
  logic   ri_elig;
  logic   ri_force;
  logic   ri_wr_win;

  assign ri_elig   = ri_req_in && !ri_busy;
  assign ri_wr_win = (win == OWN_RI) && ri_wr_in;

`ifdef PPU_VRAM_ARB_RI_TIMEOUT_EN
  logic [7:0] ri_wait_cnt;

  assign ri_force = ri_elig && ({24'd0, ri_wait_cnt} >= RI_WAIT_MAX);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ri_wait_cnt <= 8'd0;
    end else if (!ri_req_in || win == OWN_RI) begin
      ri_wait_cnt <= 8'd0;
    end else if (ri_elig && ri_wait_cnt != 8'hFF) begin
      ri_wait_cnt <= ri_wait_cnt + 8'd1;
    end
  end
`else
  assign ri_force = 1'b0;
`endif

  // NOTE: assign the default first so every path drives win and no latch is inferred.
  always_comb begin
    win = OWN_NONE;
    if (ri_force)        win = OWN_RI;
    else if (spr_req_in) win = OWN_SPR;
    else if (bg_req_in)  win = OWN_BG;
    else if (ri_elig)    win = OWN_RI;
  end

  // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      spr_gnt_out  <= 1'b0;
      bg_gnt_out   <= 1'b0;
      ri_ack_out   <= 1'b0;
      ri_d_out     <= 8'd0;
      vram_a_out   <= 14'd0;
      vram_d_out   <= 8'd0;
      vram_wr_out  <= 1'b0;
      rd_d_out     <= 8'd0;
      rd_vld_out   <= 1'b0;
      rd_owner_out <= OWN_NONE;
      s1_owner     <= OWN_NONE;
      s2_owner     <= OWN_NONE;
      ri_busy      <= 1'b0;
    end else begin
      // Address stage
      spr_gnt_out <= (win == OWN_SPR);
      bg_gnt_out  <= (win == OWN_BG);
      vram_wr_out <= ri_wr_win;
      unique case (win)
        OWN_SPR: vram_a_out <= spr_a_in;
        OWN_BG:  vram_a_out <= bg_a_in;
        OWN_RI:  vram_a_out <= ri_a_in;
        default: vram_a_out <= vram_a_out;
      endcase
      if (ri_wr_win) vram_d_out <= ri_d_in;
      // Writes carry no return tag, so they vanish from the read pipe here.
      s1_owner <= ri_wr_win ? OWN_NONE : win;

      // Data stage
      s2_owner <= s1_owner;

      // Return stage: vram_d_in belongs to the access tagged in s2_owner.
      rd_vld_out   <= (s2_owner != OWN_NONE);
      rd_owner_out <= s2_owner;
      if (s2_owner != OWN_NONE) rd_d_out <= vram_d_in;
      if (s2_owner == OWN_RI)   ri_d_out <= vram_d_in;

      ri_ack_out <= ri_wr_win || (s2_owner == OWN_RI);

      // One ri access in flight: a win sets busy, the registered ack releases it.
      if (win == OWN_RI)   ri_busy <= 1'b1;
      else if (ri_ack_out) ri_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ppu_vram_arb.sv
// Directed bench for ppu_vram_arb with a registered-read VRAM model.
// Starvation checks follow PPU_VRAM_ARB_RI_TIMEOUT_EN (RI_WAIT_MAX = 4 here).
`timescale 1ns/1ps

module tb_ppu_vram_arb;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        spr_req_in, bg_req_in, ri_req_in, ri_wr_in;
  logic [13:0] spr_a_in, bg_a_in, ri_a_in;
  logic [7:0]  ri_d_in;
  logic        spr_gnt_out, bg_gnt_out, ri_ack_out;
  logic [7:0]  ri_d_out;
  logic [7:0]  vram_d_in;
  logic [13:0] vram_a_out;
  logic [7:0]  vram_d_out;
  logic        vram_wr_out;
  logic [7:0]  rd_d_out;
  logic        rd_vld_out;
  logic [1:0]  rd_owner_out;

  int n_checks = 0;
  int n_fail   = 0;
  int acks;

  ppu_vram_arb #(.RI_WAIT_MAX(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .spr_req_in(spr_req_in), .spr_a_in(spr_a_in), .spr_gnt_out(spr_gnt_out),
    .bg_req_in(bg_req_in), .bg_a_in(bg_a_in), .bg_gnt_out(bg_gnt_out),
    .ri_req_in(ri_req_in), .ri_wr_in(ri_wr_in), .ri_a_in(ri_a_in), .ri_d_in(ri_d_in),
    .ri_ack_out(ri_ack_out), .ri_d_out(ri_d_out),
    .vram_d_in(vram_d_in), .vram_a_out(vram_a_out), .vram_d_out(vram_d_out),
    .vram_wr_out(vram_wr_out), .rd_d_out(rd_d_out), .rd_vld_out(rd_vld_out),
    .rd_owner_out(rd_owner_out)
  );

  always #5 clk_in = ~clk_in;

  // VRAM: unwritten cells hold a[7:0] ^ a[13:8]; read data appears one cycle after the address.
  bit [7:0] mem [16384];
  bit       written [16384];

  always @(posedge clk_in) begin
    if (vram_wr_out) begin
      mem[vram_a_out]     <= vram_d_out;
      written[vram_a_out] <= 1'b1;
    end
    vram_d_in <= written[vram_a_out] ? mem[vram_a_out]
                                     : (vram_a_out[7:0] ^ {2'b00, vram_a_out[13:8]});
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " spr_gnt"}, {15'd0, spr_gnt_out}, 16'h0);
    check({tag, " bg_gnt"},  {15'd0, bg_gnt_out},  16'h0);
    check({tag, " ri_ack"},  {15'd0, ri_ack_out},  16'h0);
    check({tag, " ri_d"},    {8'd0, ri_d_out},     16'h0);
    check({tag, " vram_a"},  {2'd0, vram_a_out},   16'h0);
    check({tag, " vram_d"},  {8'd0, vram_d_out},   16'h0);
    check({tag, " vram_wr"}, {15'd0, vram_wr_out}, 16'h0);
    check({tag, " rd_d"},    {8'd0, rd_d_out},     16'h0);
    check({tag, " rd_vld"},  {15'd0, rd_vld_out},  16'h0);
    check({tag, " owner"},   {14'd0, rd_owner_out}, 16'h0);
  endtask

  initial begin
    rst_in = 1'b1;
    spr_req_in = 0; bg_req_in = 0; ri_req_in = 0; ri_wr_in = 0;
    spr_a_in = '0; bg_a_in = '0; ri_a_in = '0; ri_d_in = '0;
    tick(); tick();
    rst_in = 1'b0;
    check_all_zero("reset");

    // ri read of 0x2005 on an idle bus; cell holds 0x05 ^ 0x20 = 0x25.
    ri_req_in = 1; ri_wr_in = 0; ri_a_in = 14'h2005;
    tick();
    check("ri_rd addr", {2'd0, vram_a_out}, 16'h2005);
    check("ri_rd wr", {15'd0, vram_wr_out}, 16'h0);
    tick();
    check("ri_rd early vld", {15'd0, rd_vld_out}, 16'h0);
    tick();
    check("ri_rd ack", {15'd0, ri_ack_out}, 16'h1);
    check("ri_rd vld", {15'd0, rd_vld_out}, 16'h1);
    check("ri_rd owner", {14'd0, rd_owner_out}, 16'h3);
    check("ri_rd data", {8'd0, ri_d_out}, 16'h25);
    ri_req_in = 0;
    tick();
    check("ri_rd ack pulse", {15'd0, ri_ack_out}, 16'h0);
    tick();

    // spr, bg and ri write together: serialised spr, bg, ri.
    spr_req_in = 1; spr_a_in = 14'h1234;
    bg_req_in  = 1; bg_a_in  = 14'h23C0;
    ri_req_in  = 1; ri_wr_in = 1; ri_a_in = 14'h0100; ri_d_in = 8'hA5;
    tick();
    check("tri spr_gnt", {15'd0, spr_gnt_out}, 16'h1);
    check("tri c1 addr", {2'd0, vram_a_out}, 16'h1234);
    check("tri c1 wr", {15'd0, vram_wr_out}, 16'h0);
    spr_req_in = 0;
    tick();
    check("tri bg_gnt", {15'd0, bg_gnt_out}, 16'h1);
    check("tri c2 spr_gnt", {15'd0, spr_gnt_out}, 16'h0);
    check("tri c2 addr", {2'd0, vram_a_out}, 16'h23C0);
    check("tri c2 wr", {15'd0, vram_wr_out}, 16'h0);
    bg_req_in = 0;
    tick();
    check("tri c3 addr", {2'd0, vram_a_out}, 16'h0100);
    check("tri c3 wr", {15'd0, vram_wr_out}, 16'h1);
    check("tri c3 wdata", {8'd0, vram_d_out}, 16'hA5);
    check("tri c3 ack", {15'd0, ri_ack_out}, 16'h1);
    check("tri c3 gnts", {14'd0, spr_gnt_out, bg_gnt_out}, 16'h0);
    check("tri spr rd owner", {14'd0, rd_owner_out}, 16'h2);
    check("tri spr rd data", {8'd0, rd_d_out}, 16'h26);
    ri_req_in = 0; ri_wr_in = 0;
    tick();
    check("tri c4 wr", {15'd0, vram_wr_out}, 16'h0);
    check("tri bg rd owner", {14'd0, rd_owner_out}, 16'h1);
    check("tri bg rd data", {8'd0, rd_d_out}, 16'hE3);
    tick();
    check("tri no wr return", {15'd0, rd_vld_out}, 16'h0);

    // bg streams 0x0000..0x0007 back-to-back.
    bg_req_in = 1; bg_a_in = 14'h0000;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c <= 8) begin
        check($sformatf("burst gnt %0d", c), {15'd0, bg_gnt_out}, 16'h1);
        bg_a_in = 14'(c);
        if (c == 8) bg_req_in = 0;
      end
      if (c >= 3) begin
        check($sformatf("burst vld %0d", c), {15'd0, rd_vld_out}, 16'h1);
        check($sformatf("burst owner %0d", c), {14'd0, rd_owner_out}, 16'h1);
        check($sformatf("burst data %0d", c), {8'd0, rd_d_out}, 16'(c - 3));
      end
    end
    tick();
    check("burst end vld", {15'd0, rd_vld_out}, 16'h0);

    // Starvation: spr held continuously while ri reads 0x0100 (written 0xA5 above).
    spr_req_in = 1; spr_a_in = 14'h0040;
    ri_req_in = 1; ri_wr_in = 0; ri_a_in = 14'h0100;
`ifdef PPU_VRAM_ARB_RI_TIMEOUT_EN
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c <= 4) begin
        check($sformatf("starve spr %0d", c), {2'd0, vram_a_out}, 16'h0040);
      end else if (c == 5) begin
        check("timeout ri addr", {2'd0, vram_a_out}, 16'h0100);
        check("timeout spr_gnt", {15'd0, spr_gnt_out}, 16'h0);
      end else if (c == 7) begin
        check("timeout ack", {15'd0, ri_ack_out}, 16'h1);
        check("timeout data", {8'd0, ri_d_out}, 16'hA5);
        ri_req_in = 0;
      end
    end
    spr_req_in = 0;
`else
    for (int c = 1; c <= 20; c++) begin
      tick();
      check($sformatf("starve spr %0d", c), {2'd0, vram_a_out}, 16'h0040);
      check($sformatf("starve no ack %0d", c), {15'd0, ri_ack_out}, 16'h0);
    end
    spr_req_in = 0;
    tick();
    check("starve release addr", {2'd0, vram_a_out}, 16'h0100);
    tick(); tick();
    check("starve release ack", {15'd0, ri_ack_out}, 16'h1);
    check("starve release data", {8'd0, ri_d_out}, 16'hA5);
    ri_req_in = 0;
`endif
    tick(); tick(); tick(); tick();

    // Reset one cycle after a spr grant flushes the read.
    spr_req_in = 1; spr_a_in = 14'h0300;
    tick();
    check("flush gnt", {15'd0, spr_gnt_out}, 16'h1);
    spr_req_in = 0; rst_in = 1;
    tick();
    rst_in = 0;
    check_all_zero("flush");
    tick();
    check("flush vld a", {15'd0, rd_vld_out}, 16'h0);
    tick();
    check("flush vld b", {15'd0, rd_vld_out}, 16'h0);

    // ri write 0x3C to 0x0555 then immediate read of the same cell.
    ri_req_in = 1; ri_wr_in = 1; ri_a_in = 14'h0555; ri_d_in = 8'h3C;
    acks = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (ri_ack_out) begin
        acks++;
        if (acks == 1) ri_wr_in = 0;
        else ri_req_in = 0;
      end
    end
    ri_req_in = 0;
    check("wr_rd ack count", 16'(acks), 16'd2);
    check("wr_rd data", {8'd0, ri_d_out}, 16'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
